reward_spawner: RTL and testbench
=================================

// Module: reward_spawner
// PURPOSE
//  Requester side of the reward set_require/set_finish handshake. A 16-bit LFSR picks a
//  grid cell and a reward type. After a delay the block offers them on set_require until the
//  reward consumer acknowledges pickup with set_finish, or the offer times out.
//  Sits between the game enables and the reward consumer/display; all paced by tick_4Hz.
// PARAMETERS
//  SEED          16'hACE1  LFSR reset/reload value (must be non-zero)
//  GRID_W        20        x cells; legal 16..32
//  GRID_H        15        y cells; legal 16..32 or 15 (see position rule)
//  SPAWN_DELAY   20        ticks from DELAY entry to offer (5 s)
//  OFFER_TIMEOUT 40        ticks an unclaimed offer stays up (10 s)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous active-low reset
//  tick_4Hz      in   1   single-clk strobe, 4 Hz, synchronous to clk
//  enable        in   1   reward subsystem enable (level)
//  set_finish    in   1   consumer ack: reward taken (level, held until set_require drops)
//  set_require   out  1   offer valid; position/type stable while high
//  reward_type   out  3   1..4 while offering; 0 in IDLE
//  random_xpos   out  5   offered cell x, 0..GRID_W-1
//  random_ypos   out  5   offered cell y, 0..GRID_H-1
//  dout          out  1   LFSR bit 0 (debug/LED)
//  spawn_count   out  8   offers accepted since reset, saturating at 255
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): state IDLE, LFSR=SEED, all outputs and counters 0 except dout=SEED[0].
//  LFSR: Galois, poly x^16+x^14+x^13+x^11 (mask 16'hB400), shifts every clk while enable=1.
//   Holds while enable=0. If the LFSR ever reads 0, it reloads SEED on the next clk.
//  Position: raw=lfsr[4:0] / lfsr[9:5]. If raw>=GRID, use raw-GRID (single subtract); for GRID_H=15
//   apply the subtract twice. Type = {1'b0,lfsr[11:10]}+1, range 1..4.
//  FSM (transitions take effect on posedge clk):
//   IDLE : outputs 0. enable=1 -> DELAY, tick_cnt=0.
//   DELAY: tick_cnt++ on each tick_4Hz. The tick that makes tick_cnt==SPAWN_DELAY latches
//          pos/type from the current LFSR; -> OFFER, set_require=1 in the same edge, tick_cnt=0.
//   OFFER: outputs frozen. set_finish=1 -> ACK, set_require=0 next edge, spawn_count+1.
//          Else on a tick: tick_cnt++. Reaching OFFER_TIMEOUT -> DELAY, set_require=0, no count.
//          set_finish and the timeout tick in the same cycle: set_finish wins (ACK).
//   ACK  : set_require=0, latched pos/type held. Wait for set_finish=0 -> DELAY, tick_cnt=0
//          (four-phase; no new offer while ack is still high).
//  enable=0 in any state -> IDLE next edge: set_require/type/pos cleared, tick_cnt cleared,
//   spawn_count kept.
//  rst_n=0 mid-offer: set_require drops on that edge; pending offer discarded.
//  tick_cnt width = clog2(max(SPAWN_DELAY,OFFER_TIMEOUT)+1). No combinational path from inputs
//   to outputs; all outputs registered.
// STRUCTURE
//  Shared package reward_pkg: reward type codes (RWD_NONE=0, INVINCIBLE/ADDTIME=1, FASTER=2,
//   FROZEN=3, LASER=4), grid dims, LFSR mask. Consumer and display use the same package.
//  One sub-module: reward_lfsr16 (seed, enable, zero-reload, 16-bit state out).
//  FSM, tick counter, output latches and spawn counter live in reward_spawner.
// TESTING
//  T1 reset/seed: rst_n=0 3 clks, enable=1 -> set_require=0; LFSR after 1 clk = next(16'hACE1)
//     vs golden model; 1000 clks never zero.
//  T2 spawn delay: enable=1, 20 ticks -> set_require rises on edge of 20th tick; xpos<20, ypos<15,
//     type in 1..4; values unchanged for the whole offer.
//  T3 accept: during OFFER, set_finish=1 for 5 clks -> set_require=0 1 clk later, spawn_count=1;
//     no new offer until set_finish=0 + 20 ticks.
//  T4 timeout: no set_finish, 40 ticks in OFFER -> set_require=0, spawn_count stays 0, next
//     offer after another 20 ticks.
//  T5 race: set_finish=1 on the same clk as the 40th offer tick -> ACK path, spawn_count+1.
//  T6 enable drop/reset mid-offer: enable=0 -> next clk set_require=0, type=0, spawn_count
//     kept; rst_n=0 -> all 0. 300 forced accepts -> spawn_count saturates at 255.

Source files
------------

// File: rtl/reward_pkg.sv
// reward_pkg: reward type codes, grid defaults, LFSR constants and shared state encoding
package reward_pkg;
  localparam logic [2:0] RWD_NONE       = 3'd0;
  localparam logic [2:0] RWD_INVINCIBLE = 3'd1;
  localparam logic [2:0] RWD_ADDTIME    = 3'd1;
  localparam logic [2:0] RWD_FASTER     = 3'd2;
  localparam logic [2:0] RWD_FROZEN     = 3'd3;
  localparam logic [2:0] RWD_LASER      = 3'd4;
  localparam int         GRID_W_DEF     = 20;
  localparam int         GRID_H_DEF     = 15;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_OFFER, ST_ACK} spawn_state_e;
  // Two conditional subtracts cover every legal grid, including the 15-cell height.
  function automatic logic [4:0] grid_fold(input logic [4:0] raw, input int g);
    logic [4:0] r;
    r = (int'(raw) >= g) ? raw - 5'(g) : raw;
    r = (int'(r) >= g) ? r - 5'(g) : r;
    return r;
  endfunction
endpackage

// File: rtl/reward_lfsr16.sv
// reward_lfsr16: 16-bit Galois LFSR with enable hold and zero-state recovery
module reward_lfsr16
  import reward_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q, lfsr_d;
  // Right-shift Galois step; a stuck zero state is reloaded from the seed.
  always_comb lfsr_d = (lfsr_q == 16'h0) ? SEED : en_i ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0)) : lfsr_q;
  // State register.
  always_ff @(posedge clk) lfsr_q <= !rst_n ? SEED : lfsr_d;
  assign state_o = lfsr_q;
endmodule

// File: rtl/reward_spawner.sv
// reward_spawner: delayed, timed-out reward offers over a four-phase set_require/set_finish handshake
module reward_spawner
  import reward_pkg::*;
#(
  parameter logic [15:0] SEED          = LFSR_SEED,
  parameter int          GRID_W        = GRID_W_DEF,
  parameter int          GRID_H        = GRID_H_DEF,
  parameter int          SPAWN_DELAY   = 20,
  parameter int          OFFER_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_4Hz,
  input  logic       enable,
  input  logic       set_finish,
  output logic       set_require,
  output logic [2:0] reward_type,
  output logic [4:0] random_xpos,
  output logic [4:0] random_ypos,
  output logic       dout,
  output logic [7:0] spawn_count
);
  localparam int TMAX = (SPAWN_DELAY > OFFER_TIMEOUT) ? SPAWN_DELAY : OFFER_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  spawn_state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic [2:0]    type_q, type_d;
  logic [4:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    spawn_q, spawn_d;
  logic [15:0]   lfsr;
  logic          unused_lfsr_bits;
  reward_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (enable),
    .state_o(lfsr)
  );
  assign unused_lfsr_bits = ^lfsr[15:12];
  // Offer FSM: delay ticks, latch a cell/type, hold the offer until ack or timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    type_d  = type_q;
    x_d     = x_q;
    y_d     = y_q;
    spawn_d = spawn_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      type_d  = RWD_NONE;
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
        ST_DELAY: if (tick_4Hz) begin
          if (cnt_q == TW'(SPAWN_DELAY - 1)) begin
            state_d = ST_OFFER;
            cnt_d   = '0;
            req_d   = 1'b1;
            x_d     = grid_fold(lfsr[4:0], GRID_W);
            y_d     = grid_fold(lfsr[9:5], GRID_H);
            type_d  = {1'b0, lfsr[11:10]} + 3'd1;
          end else cnt_d = cnt_q + 1'b1;
        end
        ST_OFFER: begin
          if (set_finish) begin
            state_d = ST_ACK;
            req_d   = 1'b0;
            spawn_d = (&spawn_q) ? spawn_q : spawn_q + 8'd1;
          end else if (tick_4Hz) begin
            if (cnt_q == TW'(OFFER_TIMEOUT - 1)) begin
              state_d = ST_DELAY;
              cnt_d   = '0;
              req_d   = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ACK: if (!set_finish) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // State and output registers; reset drops any pending offer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      type_q  <= RWD_NONE;
      x_q     <= '0;
      y_q     <= '0;
      spawn_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      type_q  <= type_d;
      x_q     <= x_d;
      y_q     <= y_d;
      spawn_q <= spawn_d;
    end
  end
  assign set_require = req_q;
  assign reward_type = type_q;
  assign random_xpos = x_q;
  assign random_ypos = y_q;
  assign dout        = lfsr[0];
  assign spawn_count = spawn_q;
endmodule

// File: tb/tb_reward_spawner.sv
// tb_reward_spawner: directed checks of delay, accept, timeout, race, enable drop, reset and saturation
module tb_reward_spawner;
  logic clk = 1'b0, rst_n = 1'b0, tick_4Hz = 1'b0, enable = 1'b0, set_finish = 1'b0;
  logic set_require, dout;
  logic [2:0] reward_type;
  logic [4:0] random_xpos, random_ypos;
  logic [7:0] spawn_count;
  int total = 0, bad = 0;
  logic [15:0] m = 16'hACE1, mp = 16'hACE1;
  logic [4:0] ex, ey;
  logic [2:0] et;
  reward_spawner dut (
    .clk(clk), .rst_n(rst_n), .tick_4Hz(tick_4Hz), .enable(enable), .set_finish(set_finish),
    .set_require(set_require), .reward_type(reward_type), .random_xpos(random_xpos),
    .random_ypos(random_ypos), .dout(dout), .spawn_count(spawn_count)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction
  function automatic logic [4:0] wrap(input logic [4:0] raw, input int g);
    int v;
    v = int'(raw);
    if (v >= g) v = v - g;
    if (g == 15 && v >= g) v = v - g;
    return 5'(v);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    mp = m;
    if (!rst_n) m = 16'hACE1;
    else if (m == 16'h0) m = 16'hACE1;
    else if (enable) m = nxt(m);
    #1;
  endtask
  task automatic tick_step();
    tick_4Hz = 1'b1;
    step();
    tick_4Hz = 1'b0;
    step();
  endtask
  task automatic check_offer(input string tag);
    chk({tag, "_req"}, 32'(set_require), 32'd1);
    chk({tag, "_x"}, 32'(random_xpos), 32'(ex));
    chk({tag, "_y"}, 32'(random_ypos), 32'(ey));
    chk({tag, "_type"}, 32'(reward_type), 32'(et));
  endtask
  task automatic spawn(input string tag);
    repeat (19) tick_step();
    chk({tag, "_early"}, 32'(set_require), 32'd0);
    tick_4Hz = 1'b1;
    step();
    tick_4Hz = 1'b0;
    ex = wrap(mp[4:0], 20);
    ey = wrap(mp[9:5], 15);
    et = 3'(mp[11:10]) + 3'd1;
    check_offer(tag);
    chk({tag, "_xrange"}, 32'(random_xpos < 5'd20), 32'd1);
    chk({tag, "_yrange"}, 32'(random_ypos < 5'd15), 32'd1);
    step();
  endtask
  initial begin
    enable = 1'b1;
    repeat (3) step();
    chk("t1_rst_req", 32'(set_require), 32'd0);
    chk("t1_rst_type", 32'(reward_type), 32'd0);
    chk("t1_rst_pos", 32'({random_xpos, random_ypos}), 32'd0);
    chk("t1_rst_cnt", 32'(spawn_count), 32'd0);
    chk("t1_rst_dout", 32'(dout), 32'd1);
    rst_n = 1'b1;
    step();
    chk("t1_next_model", 32'(m), 32'hE270);
    chk("t1_next_dout", 32'(dout), 32'd0);
    chk("t1_idle_req", 32'(set_require), 32'd0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t1_dout_seq", 32'(dout), 32'(m[0]));
    end
    spawn("t2_offer");
    for (int i = 0; i < 10; i++) begin
      tick_step();
      check_offer("t2_hold");
    end
    set_finish = 1'b1;
    step();
    chk("t3_req_drop", 32'(set_require), 32'd0);
    chk("t3_count", 32'(spawn_count), 32'd1);
    chk("t3_type_held", 32'(reward_type), 32'(et));
    for (int i = 0; i < 3; i++) begin
      tick_step();
      chk("t3_ack_hold", 32'(set_require), 32'd0);
    end
    set_finish = 1'b0;
    step();
    spawn("t3_next");
    repeat (39) tick_step();
    chk("t4_still_up", 32'(set_require), 32'd1);
    tick_4Hz = 1'b1;
    step();
    tick_4Hz = 1'b0;
    chk("t4_timeout_req", 32'(set_require), 32'd0);
    chk("t4_timeout_cnt", 32'(spawn_count), 32'd1);
    step();
    spawn("t4_next");
    repeat (39) tick_step();
    tick_4Hz = 1'b1;
    set_finish = 1'b1;
    step();
    tick_4Hz = 1'b0;
    chk("t5_race_req", 32'(set_require), 32'd0);
    chk("t5_race_cnt", 32'(spawn_count), 32'd2);
    set_finish = 1'b0;
    step();
    spawn("t5_next");
    enable = 1'b0;
    step();
    chk("t6_dis_req", 32'(set_require), 32'd0);
    chk("t6_dis_type", 32'(reward_type), 32'd0);
    chk("t6_dis_pos", 32'({random_xpos, random_ypos}), 32'd0);
    chk("t6_dis_cnt", 32'(spawn_count), 32'd2);
    step();
    chk("t6_dis_lfsr_hold", 32'(dout), 32'(m[0]));
    enable = 1'b1;
    step();
    spawn("t6_reen");
    rst_n = 1'b0;
    step();
    chk("t6_rst_req", 32'(set_require), 32'd0);
    chk("t6_rst_cnt", 32'(spawn_count), 32'd0);
    chk("t6_rst_type", 32'(reward_type), 32'd0);
    chk("t6_rst_dout", 32'(dout), 32'd1);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      int k;
      k = 0;
      while (!set_require && k < 30) begin
        tick_step();
        k++;
      end
      if (k == 30) begin
        chk("t6_sat_wait", 32'(set_require), 32'd1);
        break;
      end
      set_finish = 1'b1;
      step();
      set_finish = 1'b0;
      step();
      if (i == 253) chk("t6_sat_254", 32'(spawn_count), 32'd254);
    end
    chk("t6_sat_255", 32'(spawn_count), 32'd255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
